// File: rtl/nibble_serial_adder_if.sv
// Handshake bus for the nibble-serial adder: operand request and result response channels.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract built from one 4-bit CLA slice, processing one nibble per clock
// with the carry held in a register between nibbles.
module adder_4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c0,
  output logic [3:0] F,
  output logic       c4
);
  logic [3:0] g, p;
  logic       c1, c2, c3;

  assign g  = x & y;
  assign p  = x ^ y;
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);
  assign F  = p ^ {c3, c2, c1, c0};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, sum_q, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             out_valid_q, cout_q, ovf_q, zero_q;
  logic [3:0]       f;
  logic             c4;
  logic             last, accept;

  adder_4 u_slice (
    .x  (a_reg[3:0]),
    .y  (b_reg[3:0]),
    .c0 (carry),
    .F  (f),
    .c4 (c4)
  );

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = (cnt == CW'(NIB - 1));
  assign acc_nxt       = {f, acc[WIDTH-1:4]};
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
            a_reg <= bus.a;
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          acc   <= acc_nxt;
          carry <= c4;
          if (last) begin
            // Last slice holds the MSBs: carry into the MSB is a ^ b' ^ sum there.
            sum_q       <= acc_nxt;
            cout_q      <= c4;
            ovf_q       <= a_reg[3] ^ b_reg[3] ^ f[3] ^ c4;
            zero_q      <= (acc_nxt == '0);
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against an arithmetic reference model.
module tb_nibble_serial_adder;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errs   = 0;
  int   cyc    = 0;
  int   acc_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] es, output logic ec, output logic eo,
                           output logic ez);
    logic [32:0] full;
    logic [31:0] bb;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 33'(s);
    es   = full[31:0];
    ec   = full[32];
    if (s) eo = (a[31] != b[31]) && (es[31] != a[31]);
    else   eo = (a[31] == b[31]) && (es[31] != a[31]);
    ez   = (es == 32'd0);
  endtask

  // Returns at the negedge just after the accept edge.
  task automatic wait_accept();
    int k;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("accept_seen", bus.in_ready, 1);
    @(negedge clk);
    chk("in_ready_run", bus.in_ready, 0);
  endtask

  // Entered at the negedge after the accept edge; leaves at the negedge where out_valid is high.
  task automatic wait_result(input logic [31:0] a, input logic [31:0] b, input logic s);
    int          k;
    logic [31:0] es;
    logic        ec, eo, ez;
    ref_model(a, b, s, es, ec, eo, ez);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 8);
    chk("sum", bus.sum, es);
    chk("cout", bus.cout, ec);
    chk("ovf", bus.ovf, eo);
    chk("zero", bus.zero, ez);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_idle", bus.in_ready, 1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int bp);
    logic [31:0] held;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_accept();
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
    wait_result(a, b, s);
    held = bus.sum;
    repeat (bp) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_sum", bus.sum, held);
    end
    release_result();
  endtask

  initial begin
    logic [31:0] es, ra, rb;
    logic        ec, eo, ez, rs;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", bus.in_ready, 1);

    run_op(32'h0000000F, 32'h00000001, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1);
    run_op(32'h00000005, 32'h00000007, 1'b1, 0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 2);
    run_op(32'h00001234, 32'h00001234, 1'b1, 0);

    // Backpressure with a new request pending during DONE.
    @(negedge clk);
    bus.a = 32'h00000100; bus.b = 32'h00000023; bus.sub = 1'b0; bus.in_valid = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    wait_result(32'h00000100, 32'h00000023, 1'b0);
    bus.a = 32'hAAAA0000; bus.b = 32'h00005555; bus.sub = 1'b1; bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum", bus.sum, 32'h00000123);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    release_result();
    wait_accept();
    bus.in_valid = 1'b0;
    wait_result(32'hAAAA0000, 32'h00005555, 1'b1);
    release_result();

    // Reset in the middle of RUN.
    @(negedge clk);
    bus.a = 32'h3; bus.b = 32'h4; bus.sub = 1'b0; bus.in_valid = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1 chk("midrst_release", bus.in_ready, 1);
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_result", bus.out_valid, 0);
    end
    run_op(32'h1, 32'h1, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    acc_q.delete();
    bus.a = 32'h12345678; bus.b = 32'h11111111; bus.sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    wait_accept();
    bus.a = 32'h10; bus.b = 32'h20; bus.sub = 1'b1;
    wait_result(32'h12345678, 32'h11111111, 1'b0);
    wait_accept();
    bus.in_valid = 1'b0;
    wait_result(32'h10, 32'h20, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 10);

    // Random operations with random backpressure.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = 32'h80000000;
      run_op(ra, rb, rs, int'($urandom_range(0, 3)));
    end

    ref_model(32'h0, 32'h0, 1'b0, es, ec, eo, ez);
    run_op(32'h0, 32'h0, 1'b0, 0);
    chk("final_zero_model", {31'd0, ez}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
